// File: rtl/css_mcu0_el2_pkg.sv
// Shared types for the EL2 DCCM SRAM sink: sweep FSM states and the stored bank word layout.
package css_mcu0_el2_pkg;

    localparam int DCCM_DATA_WIDTH = 32;
    localparam int DCCM_ECC_WIDTH  = 7;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } dccm_sink_state_e;

    // Bank word as stored in the array: ECC in the upper bits, data below.
    typedef struct packed {
        logic [DCCM_ECC_WIDTH-1:0]  ecc;
        logic [DCCM_DATA_WIDTH-1:0] data;
    } dccm_word_t;

endpackage

// File: rtl/css_mcu0_el2_dccm_sink_bank.sv
// One behavioural DCCM bank: single-port array, 1-cycle registered read, write path with optional XOR corruption.
module css_mcu0_el2_dccm_sink_bank
    import css_mcu0_el2_pkg::*;
#(
    parameter int DATA_WIDTH = DCCM_DATA_WIDTH,
    parameter int ECC_WIDTH  = DCCM_ECC_WIDTH,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic                            we,
    input  logic                            re,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] wr_word,
    input  logic                            inj_en,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] inj_mask,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic [ECC_WIDTH-1:0]            ecc
);

    localparam int WORD_W = DATA_WIDTH + ECC_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [WORD_W-1:0] store_s;
    logic [WORD_W-1:0] rd_word_r;

    // Write data mux: corrupt the stored word only when an armed injection is consumed here.
    always_comb begin
        store_s = wr_word;
        if (inj_en) begin
            store_s = wr_word ^ inj_mask;
        end else begin
            store_s = wr_word;
        end
    end

    // Array write port; contents are deliberately not reset, like a real macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= store_s;
        end
    end

    // Read register: loads only on a read, otherwise holds the last value.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_word_r <= '0;
        end else if (re) begin
            rd_word_r <= mem_r[addr];
        end else begin
            rd_word_r <= rd_word_r;
        end
    end

    assign {ecc, dout} = rd_word_r;

endmodule

// File: rtl/css_mcu0_el2_dccm_sram_sink.sv
// DCCM SRAM sink endpoint: per-bank behavioural arrays, zero-init sweep FSM and one-shot ECC error injection.
module css_mcu0_el2_dccm_sram_sink
    import css_mcu0_el2_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                              clk,
    input  logic                              rst_l,
    input  logic [NUM_BANKS-1:0]              dccm_clken,
    input  logic [NUM_BANKS-1:0]              dccm_wren_bank,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]   dccm_addr_bank,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]   dccm_wr_data_bank,
    input  logic [NUM_BANKS*ECC_WIDTH-1:0]    dccm_wr_ecc_bank,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]   dccm_bank_dout,
    output logic [NUM_BANKS*ECC_WIDTH-1:0]    dccm_bank_ecc,
    input  logic                              init_start,
    output logic                              init_done,
    input  logic                              err_inj_valid,
    input  logic [$clog2(NUM_BANKS)-1:0]      err_inj_bank,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0]   err_inj_mask,
    output logic                              err_inj_armed
);

    localparam int WORD_W = DATA_WIDTH + ECC_WIDTH;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    // ptr carries one extra bit so the terminal count never aliases with zero.
    localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    dccm_sink_state_e        state_r, state_next_s;
    logic [ADDR_WIDTH:0]     ptr_r, ptr_next_s;
    logic                    armed_r;
    logic [BANK_W-1:0]       inj_bank_r;
    logic [WORD_W-1:0]       inj_mask_r;
    logic                    sweep_s;
    logic                    idle_s;
    logic                    consume_s;

    // Sweep FSM state and pointer registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r <= INIT;
            ptr_r   <= '0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
        end
    end

    // Sweep FSM next state: one address per cycle, restart on init_start.
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            INIT: begin
                if (init_start) begin
                    ptr_next_s = '0;
                end else if (ptr_r == PTR_LAST) begin
                    state_next_s = IDLE;
                    ptr_next_s   = '0;
                end else begin
                    ptr_next_s = ptr_r + (ADDR_WIDTH+1)'(1);
                end
            end
            IDLE: begin
                if (init_start) begin
                    state_next_s = INIT;
                    ptr_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = INIT;
                ptr_next_s   = '0;
            end
        endcase
    end

    assign sweep_s   = (state_r == INIT);
    assign idle_s    = (state_r == IDLE);
    assign consume_s = idle_s & armed_r & dccm_clken[inj_bank_r] & dccm_wren_bank[inj_bank_r];

    // Injection request: a new request wins over consumption of the old one in the same cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            armed_r    <= 1'b0;
            inj_bank_r <= '0;
            inj_mask_r <= '0;
        end else if (err_inj_valid) begin
            armed_r    <= 1'b1;
            inj_bank_r <= err_inj_bank;
            inj_mask_r <= err_inj_mask;
        end else if (consume_s) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= armed_r;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  we_s;
        logic                  re_s;
        logic [ADDR_WIDTH-1:0] addr_s;
        logic [WORD_W-1:0]     word_s;
        logic                  inj_en_s;

        assign we_s     = sweep_s | (idle_s & dccm_clken[b] & dccm_wren_bank[b]);
        assign re_s     = idle_s & dccm_clken[b] & ~dccm_wren_bank[b];
        assign addr_s   = sweep_s ? ptr_r[ADDR_WIDTH-1:0] : dccm_addr_bank[b*ADDR_WIDTH +: ADDR_WIDTH];
        assign word_s   = sweep_s ? '0 : {dccm_wr_ecc_bank[b*ECC_WIDTH +: ECC_WIDTH],
                                          dccm_wr_data_bank[b*DATA_WIDTH +: DATA_WIDTH]};
        assign inj_en_s = consume_s & (inj_bank_r == BANK_W'(b));

        css_mcu0_el2_dccm_sink_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ECC_WIDTH  (ECC_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk      (clk),
            .rst_l    (rst_l),
            .we       (we_s),
            .re       (re_s),
            .addr     (addr_s),
            .wr_word  (word_s),
            .inj_en   (inj_en_s),
            .inj_mask (inj_mask_r),
            .dout     (dccm_bank_dout[b*DATA_WIDTH +: DATA_WIDTH]),
            .ecc      (dccm_bank_ecc[b*ECC_WIDTH +: ECC_WIDTH])
        );
    end

    assign init_done     = idle_s;
    assign err_inj_armed = armed_r;

endmodule
